// File: rtl/if_id_queue_if.sv
// Fetch-to-decode handshake bundle for the IF/ID instruction queue.
// The fetch side drives if_* and sees if_ready; the queue drives id_*.
interface if_id_queue_if #(
    parameter int ADDR_W = 17,
    parameter int INST_W = 32
);
    logic              if_valid;
    logic [ADDR_W-1:0] if_pc;
    logic [INST_W-1:0] if_inst;
    logic              if_ready;
    logic              id_valid;
    logic [ADDR_W-1:0] id_pc;
    logic [INST_W-1:0] id_inst;

    // Fetch unit / stimulus side.
    modport master (
        output if_valid, if_pc, if_inst,
        input  if_ready, id_valid, id_pc, id_inst
    );

    // The queue itself.
    modport slave (
        input  if_valid, if_pc, if_inst,
        output if_ready, id_valid, id_pc, id_inst
    );
endinterface

// File: rtl/if_id_queue.sv
// IF->ID boundary stage: a DEPTH-entry instruction FIFO feeding a registered
// decode output. Fetch runs ahead while decode stalls. Two-level flush:
// flush_ex beats id_stall, and id_stall beats flush_id.
module if_id_queue #(
    parameter int ADDR_W = 17,
    parameter int INST_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush_ex,
    input  logic                         flush_id,
    input  logic                         id_stall,
    if_id_queue_if.slave                 bus,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } entry_t;

    // What the output register does this cycle.
    typedef enum logic [2:0] {
        ACT_CLEAR,   // flush: empty FIFO, bubble out
        ACT_HOLD,    // stall: keep output, FIFO may still fill
        ACT_POP,     // load output from FIFO head
        ACT_BYPASS,  // empty FIFO: fetched instruction goes straight out
        ACT_BUBBLE   // nothing to issue
    } act_e;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count_q;
    logic               out_valid;
    logic [ADDR_W-1:0]  out_pc;
    logic [INST_W-1:0]  out_inst;

    act_e               act;
    logic               ready;
    logic               accept;
    logic               enq;
    logic               deq;

    // Back-pressure depends on the registered occupancy only, so there is
    // no combinational path from stall/flush into the fetch unit.
    assign ready  = (count_q != CNT_W'(DEPTH));
    assign accept = bus.if_valid && ready && !flush_ex && !(flush_id && !id_stall);

    // Priority decode of the per-cycle action.
    // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
    always_comb begin
        act = ACT_BUBBLE;
        if (flush_ex)             act = ACT_CLEAR;
        else if (id_stall)        act = ACT_HOLD;
        else if (flush_id)        act = ACT_CLEAR;
        else if (count_q != '0)   act = ACT_POP;
        else if (accept)          act = ACT_BYPASS;
    end

    // A bypassed fetch is never written into the FIFO.
    assign enq = accept && ((act == ACT_HOLD) || (act == ACT_POP));
    assign deq = (act == ACT_POP);

    // Entry storage, written at the tail on enqueue.
    // NOTE: the data array has no reset; pointers and count alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem[wr_ptr] <= '{pc: bus.if_pc, inst: bus.if_inst};
        end
    end

    // Pointers, occupancy and the decode output register.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || act == ACT_CLEAR) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count_q   <= '0;
            out_valid <= 1'b0;
            out_pc    <= '0;
            out_inst  <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
            if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({enq, deq})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase

            case (act)
                ACT_POP: begin
                    out_valid <= 1'b1;
                    out_pc    <= mem[rd_ptr].pc;
                    out_inst  <= mem[rd_ptr].inst;
                end
                ACT_BYPASS: begin
                    out_valid <= 1'b1;
                    out_pc    <= bus.if_pc;
                    out_inst  <= bus.if_inst;
                end
                ACT_BUBBLE: begin
                    out_valid <= 1'b0;
                    out_pc    <= '0;
                    out_inst  <= '0;
                end
                default: begin
                    out_valid <= out_valid;
                    out_pc    <= out_pc;
                    out_inst  <= out_inst;
                end
            endcase
        end
    end

    assign bus.if_ready = ready;
    assign bus.id_valid = out_valid;
    assign bus.id_pc    = out_pc;
    assign bus.id_inst  = out_inst;
    assign count        = count_q;

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue. A scoreboard queue holds accepted
// instructions; entries are pushed on acceptance and popped when the
// decode output is expected to load them.
module tb_if_id_queue;
    localparam int ADDR_W = 17;
    localparam int INST_W = 32;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH+1);

    typedef logic [ADDR_W+INST_W-1:0] ent_t;

    logic clk = 1'b0;
    logic rst;
    logic flush_ex;
    logic flush_id;
    logic id_stall;
    logic [CNT_W-1:0] count;

    if_id_queue_if #(.ADDR_W(ADDR_W), .INST_W(INST_W)) bus ();

    if_id_queue #(.ADDR_W(ADDR_W), .INST_W(INST_W), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush_ex (flush_ex),
        .flush_id (flush_id),
        .id_stall (id_stall),
        .bus      (bus),
        .count    (count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Expected state: FIFO contents and the output register.
    ent_t              exp_q [$];
    logic              exp_valid;
    logic [ADDR_W-1:0] exp_pc;
    logic [INST_W-1:0] exp_inst;
    logic [ADDR_W-1:0] next_pc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [INST_W-1:0] inst_of(input logic [ADDR_W-1:0] pc);
        return 32'hC0DE_0000 ^ {15'b0, pc};
    endfunction

    // One clock cycle: drive at negedge, check if_ready, update the model,
    // check outputs 1 time unit after the rising edge.
    task automatic step(input logic r, input logic v, input logic s, input logic fe,
                        input logic fi, input logic [ADDR_W-1:0] pc, output logic acc);
        logic ready_exp;
        ent_t e;
        rst          = r;
        bus.if_valid = v;
        bus.if_pc    = pc;
        bus.if_inst  = inst_of(pc);
        id_stall     = s;
        flush_ex     = fe;
        flush_id     = fi;
        #1;
        ready_exp = (exp_q.size() < DEPTH);
        check("if_ready", 64'(bus.if_ready), 64'(ready_exp));
        acc = v && ready_exp && !fe && !(fi && !s) && !r;

        if (r || fe) begin
            exp_q.delete();
            exp_valid = 1'b0; exp_pc = '0; exp_inst = '0;
        end else if (s) begin
            if (acc) exp_q.push_back({pc, inst_of(pc)});
        end else if (fi) begin
            exp_q.delete();
            exp_valid = 1'b0; exp_pc = '0; exp_inst = '0;
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            exp_valid = 1'b1;
            exp_pc    = e[ADDR_W+INST_W-1:INST_W];
            exp_inst  = e[INST_W-1:0];
            if (acc) exp_q.push_back({pc, inst_of(pc)});
        end else if (acc) begin
            exp_valid = 1'b1; exp_pc = pc; exp_inst = inst_of(pc);
        end else begin
            exp_valid = 1'b0; exp_pc = '0; exp_inst = '0;
        end

        @(posedge clk);
        #1;
        check("id_valid", 64'(bus.id_valid), 64'(exp_valid));
        check("id_pc",    64'(bus.id_pc),    64'(exp_pc));
        check("id_inst",  64'(bus.id_inst),  64'(exp_inst));
        check("count",    64'(count),        64'(exp_q.size()));
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, acc);
    endtask

    // Present n sequential PCs from base, retrying each until accepted;
    // stall_mask bit c is id_stall in cycle c.
    task automatic run_stream(input logic [ADDR_W-1:0] base, input int n,
                              input logic [63:0] stall_mask, input int cycles);
        int   idx;
        logic acc;
        logic v;
        idx = 0;
        for (int c = 0; c < cycles; c++) begin
            v = (idx < n);
            step(1'b0, v, stall_mask[c], 1'b0, 1'b0, base + ADDR_W'(idx * 4), acc);
            if (acc) idx++;
        end
        check("stream_accepted", 64'(idx), 64'(n));
    endtask

    initial begin
        logic acc;
        rst = 1'b1; flush_ex = 1'b0; flush_id = 1'b0; id_stall = 1'b0;
        bus.if_valid = 1'b0; bus.if_pc = '0; bus.if_inst = '0;
        exp_valid = 1'b0; exp_pc = '0; exp_inst = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state, then a 3-instruction unstalled stream (bypass path).
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, acc);
        run_stream(17'h0, 3, 64'h0, 3);
        idle(2);

        // Six instructions with a 5-cycle stall: fills to DEPTH, drops ready.
        run_stream(17'h10, 6, 64'b11_1110, 12);
        idle(6);

        // Fill to 3 under stall, then flush_ex with stall and a live fetch.
        run_stream(17'h40, 3, 64'hFFFF_FFFF_FFFF_FFFF, 3);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 17'h50, acc);
        check("flush_ex_discards_fetch", 64'(acc), 64'(0));
        idle(1);

        // flush_id overridden by stall (queue grows), then takes effect.
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 17'h5c, acc);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 17'h60, acc);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 17'h64, acc);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 17'h68, acc);
        idle(1);

        // Wrap-around: 3*DEPTH instructions with alternating stall.
        run_stream(17'h200, 3 * DEPTH, 64'hAAAA_AAAA_AAAA_AAAA, 40);
        idle(6);

        // Reset mid-stream with count = 2 and id_valid = 1.
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 17'h100, acc);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 17'h104, acc);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 17'h108, acc);
        check("pre_reset_count", 64'(count), 64'(2));
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 17'h10c, acc);
        idle(1);

        // Random mix of fetch, stall, flushes and the occasional reset.
        next_pc = 17'h400;
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(63) == 0), ($urandom_range(3) != 0),
                 ($urandom_range(2) == 0), ($urandom_range(15) == 0),
                 ($urandom_range(7) == 0), next_pc, acc);
            if (acc) next_pc = next_pc + 17'd4;
        end
        idle(6);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/if_id_queue.md
# if_id_queue

Parametrised IF→ID boundary stage, successor to the single-entry IF/ID register. It places a DEPTH-entry instruction FIFO in front of a registered decode output. Fetch can run ahead while decode stalls, and a ready signal back-pressures fetch. The block keeps the existing two-level flush (EX jump, ID jump) and stall priority, and sits between the fetch unit and the decoder.

## Interface
- ADDR_W, 17, PC width (RAM address width)
- INST_W, 32, instruction width
- DEPTH, 4, FIFO entries; power of two, ≥2
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- flush_ex  in  1  jump resolved in EX; highest-priority flush
- flush_id  in  1  jump resolved in ID; flush, overridden by id_stall
- id_stall  in  1  decode/issue stall; hold output register
- if_valid  in  1  fetch presents an instruction this cycle
- if_pc  in  ADDR_W  PC of fetched instruction
- if_inst  in  INST_W  fetched instruction
- if_ready  out  1  combinational; 1 when count < DEPTH
- id_valid  out  1  id_pc/id_inst hold a real instruction
- id_pc  out  ADDR_W  PC to decode; 0 when bubble
- id_inst  out  INST_W  instruction to decode; 0 when bubble
- count  out  clog2(DEPTH+1)  FIFO occupancy; excludes output register

## Operation
- Storage: DEPTH-entry circular buffer of {pc, inst}, rd_ptr/wr_ptr of clog2(DEPTH) bits wrapping modulo DEPTH, plus the output register {id_valid, id_pc, id_inst}.
- Accept: fetch is accepted when if_valid && if_ready && !flush_ex && !(flush_id && !id_stall).
- Per cycle, the first matching rule applies:
  1. rst or flush_ex: pointers and count = 0. id_valid = 0, id_pc = 0, id_inst = 0. Input is discarded.
  2. id_stall: output register holds. FIFO enqueues an accepted fetch and does not dequeue. flush_id is ignored this cycle and must be held by its source until accepted.
  3. flush_id: FIFO cleared, output register zeroed (bubble), input discarded.
  4. Advance: if count > 0, the output register loads the FIFO head (rd_ptr++), and an accepted fetch is enqueued in the same cycle. If count = 0 and the fetch is accepted, it bypasses straight into the output register and is not enqueued. Otherwise the output becomes a bubble (valid 0, pc/inst 0).
- count rules:
  - +1 on enqueue without dequeue, −1 on dequeue without enqueue, unchanged on both or neither.
  - Never exceeds DEPTH or goes below 0.
- Full: if_ready = 0, so no enqueue even in a cycle that dequeues; fetch retries next cycle.
- Order: instructions reach id_* strictly in acceptance order; none are duplicated or dropped unless flushed.

## Timing
- Reset values: id_valid 0, id_pc 0, id_inst 0, count 0, if_ready 1 (first cycle after rst).
- Latency, empty and unstalled: an instruction accepted at edge N appears on id_* after edge N (1 cycle).
- Latency, non-empty queue: 1 cycle per entry ahead of it, plus 1.
- Throughput: 1 instruction/cycle sustained with no stall.
- if_ready reflects the registered count only; it has no combinational path from id_stall or flush inputs.
- flush_ex and flush_id take effect at the edge on which they are sampled. A reset or flush in mid-stream discards all queued entries in that single cycle.
- flush_ex together with id_stall: flush wins.
- flush_id together with id_stall: stall wins, and the queue still fills.

## Test plan
- Reset, then stream PCs 0x0,0x4,0x8 with no stall → id_pc = 0x0,0x4,0x8 on consecutive cycles, each 1 cycle after its input; count stays 0.
- Stream 0x10..0x24 (6 instructions) with id_stall high for 5 cycles, DEPTH = 4 → output holds the first instruction; count reaches 4 and if_ready drops. After release, id_pc steps through the rest in order with no loss; if_ready returns to 1 once count < 4.
- Fill to count = 3, then pulse flush_ex together with id_stall → next cycle id_valid 0, id_pc 0, id_inst 0, count 0; the concurrent if input is not enqueued.
- Assert flush_id with id_stall high → output unchanged and queue grows. Keep flush_id high, drop id_stall → bubble, count 0.
- Wrap-around: 3×DEPTH instructions with alternating stall cycles → ordering preserved across pointer wrap; count never exceeds DEPTH.
- Reset asserted mid-stream with count = 2 and id_valid = 1 → all outputs return to reset values after one edge.
